// File: rtl/seg7_scan_4digit.sv
// seg7_scan_4digit: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Scans digits 0..3, each for CLK_DIV cycles, and
// drives registered active-low anode, segment and decimal-point lines.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (leading-zero blanking
// of digits 3..1).
module seg7_scan_4digit #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    nibble;
  logic [3:0]    dark;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Prescaler and digit index; idx wraps 3 -> 0 naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Per-digit dark mask: blank input, optionally ORed with leading-zero test
  always_comb begin
    dark = blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    dark[3] = blank[3] | (data[15:12] == 4'h0);
    dark[2] = blank[2] | (data[15:8]  == 8'h00);
    dark[1] = blank[1] | (data[15:4]  == 12'h000);
`endif
  end

  // Next pin values for the currently selected digit
  always_comb begin
    nibble = data[{idx, 2'b00} +: 4];
    an_n   = 4'b1111;
    seg_n  = 7'h7F;
    dp_n   = 1'b1;
    if (!dark[idx]) begin
      an_n  = ~(4'b0001 << idx);
      seg_n = decode(nibble);
      dp_n  = ~dp_in[idx];
    end
  end

  // Registered outputs keep the pins glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end

endmodule
